seven_scan: RTL

Time-multiplexed scan controller for the 8-digit seven-segment display. It shares one cathode bus among eight digit segment vectors, each produced by a `seven_decimal` instance. Each digit gets a fixed time slot with a ghosting blank, per-slot latching of segment data, and PWM brightness control. It sits between the per-digit segment decoders and the board pins. It replaces direct parallel `segments[8]` drive.

---
 rtl/seven_scan_pkg.sv | 17 +
 rtl/seven_scan_if.sv | 26 ++
 rtl/seven_pwm.sv | 26 ++
 rtl/seven_scan.sv | 109 ++++++++++
 4 files changed

// File: rtl/seven_scan_pkg.sv
// Shared types and constants for the 8-digit seven-segment scan path.
package seven_pkg;

  localparam int DIGITS = 8;

  typedef logic [7:0] seg_t;

  typedef enum logic {SCAN_BLANK, SCAN_DRIVE} scan_state_t;

  localparam seg_t SEG_OFF = 8'hFF;

  // Active-low one-cold anode select for a digit index.
  function automatic logic [7:0] anode_sel(input logic [2:0] idx);
    anode_sel = ~(8'd1 << idx);
  endfunction

endpackage

// File: rtl/seven_scan_if.sv
// Bundle between the per-digit decoders, the scan controller and the board pins.
interface seven_scan_if;
  import seven_pkg::*;

  // No handshake: segment data, enables and brightness are level inputs sampled
  // only at the BLANK->DRIVE edge of each slot; outputs are registered levels.
  seg_t              segments_in [DIGITS];
  logic [DIGITS-1:0] digit_enable;
  logic [3:0]        brightness;
  seg_t              ca;
  logic [7:0]        an;
  logic              frame_start;
  scan_state_t       dbg_state;
  logic [2:0]        dbg_idx;

  modport master (
    output segments_in, digit_enable, brightness,
    input  ca, an, frame_start, dbg_state, dbg_idx
  );

  modport slave (
    input  segments_in, digit_enable, brightness,
    output ca, an, frame_start, dbg_state, dbg_idx
  );

endinterface

// File: rtl/seven_pwm.sv
// 4-bit brightness PWM: free-running counter, cleared at slot latch, compared to level.
module seven_pwm (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic [3:0] level,
  output logic       on
);

  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;

  assign w_cnt_next = clear ? 4'd0 : r_cnt + 4'd1;

  // Compare against the next count so the registered outputs line up with it.
  assign on = (w_cnt_next <= level);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= 4'd0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

endmodule

// File: rtl/seven_scan.sv
// Time-multiplexed scan controller: one shared cathode bus, eight digit slots,
// each slot a ghosting blank followed by a PWM-dimmed drive phase.
module seven_scan
  import seven_pkg::*;
#(
  parameter int CLKS_PER_DIGIT = 100000,
  parameter int BLANK_CLKS     = 1000
) (
  input logic         clk,
  input logic         resetn,
  seven_scan_if.slave bus
);

  localparam int SW = $clog2(CLKS_PER_DIGIT);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(CLKS_PER_DIGIT - 1);
  localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CLKS - 1);

  generate
    if (BLANK_CLKS < 1 || BLANK_CLKS >= CLKS_PER_DIGIT) begin : g_bad_params
      $fatal(1, "seven_scan: need 1 <= BLANK_CLKS < CLKS_PER_DIGIT");
    end
  endgenerate

  scan_state_t   r_state;
  logic [2:0]    r_idx;
  logic [SW-1:0] r_slot_cnt;
  seg_t          r_seg_q;
  logic          r_en_q;
  logic [3:0]    r_bri_q;
  logic [7:0]    r_an;
  seg_t          r_ca;
  logic          r_frame_start;

  logic          w_slot_wrap;
  logic          w_latch;
  logic          w_slot_end;
  logic [SW-1:0] w_slot_next;
  scan_state_t   w_state_next;
  logic [2:0]    w_idx_next;
  seg_t          w_seg_next;
  logic          w_en_next;
  logic [3:0]    w_bri_next;
  logic          w_pwm_on;
  logic          w_lit;
  logic          w_frame_next;

  assign w_slot_wrap = (r_slot_cnt == SLOT_LAST);
  assign w_latch     = (r_state == SCAN_BLANK) && (r_slot_cnt == BLANK_LAST);
  assign w_slot_end  = (r_state == SCAN_DRIVE) && w_slot_wrap;
  assign w_slot_next = w_slot_wrap ? '0 : r_slot_cnt + SW'(1);

  always_comb begin
    w_state_next = r_state;
    if (w_latch) begin
      w_state_next = SCAN_DRIVE;
    end else if (w_slot_end) begin
      w_state_next = SCAN_BLANK;
    end
  end

  assign w_idx_next = w_slot_end ? r_idx + 3'd1 : r_idx;

  // Per-slot snapshot keeps the digit tear-free against mid-slot input changes.
  assign w_seg_next = w_latch ? bus.segments_in[r_idx] : r_seg_q;
  assign w_en_next  = w_latch ? bus.digit_enable[r_idx] : r_en_q;
  assign w_bri_next = w_latch ? bus.brightness : r_bri_q;

  seven_pwm u_pwm (
    .clk   (clk),
    .resetn(resetn),
    .clear (w_latch),
    .level (w_bri_next),
    .on    (w_pwm_on)
  );

  assign w_lit        = (w_state_next == SCAN_DRIVE) && w_en_next && w_pwm_on;
  assign w_frame_next = w_slot_end && (w_idx_next == 3'd0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= SCAN_BLANK;
      r_idx         <= 3'd0;
      r_slot_cnt    <= '0;
      r_seg_q       <= SEG_OFF;
      r_en_q        <= 1'b0;
      r_bri_q       <= 4'd0;
      r_an          <= 8'hFF;
      r_ca          <= SEG_OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_idx         <= w_idx_next;
      r_slot_cnt    <= w_slot_next;
      r_seg_q       <= w_seg_next;
      r_en_q        <= w_en_next;
      r_bri_q       <= w_bri_next;
      r_an          <= w_lit ? anode_sel(w_idx_next) : 8'hFF;
      r_ca          <= w_lit ? w_seg_next : SEG_OFF;
      r_frame_start <= w_frame_next;
    end
  end

  assign bus.an          = r_an;
  assign bus.ca          = r_ca;
  assign bus.frame_start = r_frame_start;
  assign bus.dbg_state   = r_state;
  assign bus.dbg_idx     = r_idx;

endmodule
